// File: rtl/cfg_reg_arbiter.sv
// Configuration register bank shared between NUM_REQ requesters through a
// round-robin arbiter with a level request / single-cycle acknowledge handshake.
module cfg_reg_arbiter #(
  parameter  int NUM_REQ  = 2,
  parameter  int NUM_REGS = 8,
  parameter  int REG_W    = 8,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       ena,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*REG_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic [REG_W-1:0]           rdata,
  output logic                       err,
  output logic                       busy,
  output logic [NUM_REGS*REG_W-1:0]  config_regs
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cand;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic               grant_start;
  logic [IDX_W-1:0]   win;
  logic               lat_we;
  logic [ADDR_W-1:0]  lat_addr;
  logic [REG_W-1:0]   lat_wdata;
  logic               in_range;
  logic [REG_W-1:0]   mem [NUM_REGS];

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    cand  = '0;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign grant_start = (state == IDLE) && ena && found;
  assign in_range    = (int'(lat_addr) < NUM_REGS);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_start) state_next = GRANT;
      GRANT:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The winner's request is frozen in IDLE so later input changes cannot
  // corrupt a transaction that is already under way.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < NUM_REGS; k++) mem[k] <= '0;
      ptr       <= '0;
      win       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ack       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_start) begin
            win       <= pick;
            lat_we    <= we[pick];
            lat_addr  <= addr[int'(pick)*ADDR_W +: ADDR_W];
            lat_wdata <= wdata[int'(pick)*REG_W +: REG_W];
          end
        end
        GRANT: begin
          ack <= NUM_REQ'(1) << win;
          ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          if (!in_range) begin
            err   <= 1'b1;
            rdata <= '0;
          end else if (lat_we) begin
            mem[lat_addr] <= lat_wdata;
            rdata         <= '0;
          end else begin
            rdata <= mem[lat_addr];
          end
        end
        DONE: begin
          ack   <= '0;
          rdata <= '0;
          err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign config_regs[k*REG_W +: REG_W] = mem[k];
  end

endmodule

// File: tb/tb_cfg_reg_arbiter.sv
// Directed bench for cfg_reg_arbiter: transactions are queued when requested and
// checked against a register model when their acknowledge pulse appears.
module tb_cfg_reg_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int NUM_REGS = 6;
  localparam int REG_W    = 8;
  localparam int ADDR_W   = 3;

  logic                      clk = 1'b0;
  logic                      rstb = 1'b0;
  logic                      ena = 1'b0;
  logic [NUM_REQ-1:0]        req = '0;
  logic [NUM_REQ-1:0]        we = '0;
  logic [NUM_REQ*ADDR_W-1:0] addr = '0;
  logic [NUM_REQ*REG_W-1:0]  wdata = '0;
  logic [NUM_REQ-1:0]        ack;
  logic [REG_W-1:0]          rdata;
  logic                      err;
  logic                      busy;
  logic [NUM_REGS*REG_W-1:0] config_regs;

  typedef struct {
    int                 idx;
    logic               w;
    logic [ADDR_W-1:0]  a;
    logic [REG_W-1:0]   d;
    int                 t0;
  } txn_t;

  txn_t             sb[$];
  logic [REG_W-1:0] model [NUM_REGS];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_ack = 0;
  int prev_ack = 0;
  int t_ena = 0;

  cfg_reg_arbiter #(.NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .REG_W(REG_W)) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .config_regs(config_regs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NUM_REGS*REG_W-1:0] model_flat();
    logic [NUM_REGS*REG_W-1:0] f;
    for (int k = 0; k < NUM_REGS; k++) f[k*REG_W +: REG_W] = model[k];
    return f;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int i, input logic w, input logic [ADDR_W-1:0] a,
                               input logic [REG_W-1:0] d);
    txn_t t;
    we[i] = w;
    addr[i*ADDR_W +: ADDR_W] = a;
    wdata[i*REG_W +: REG_W] = d;
    req[i] = 1'b1;
    t = '{i, w, a, d, cyc};
    sb.push_back(t);
  endtask

  // Waits (bounded) for the next ack pulse and checks it against the oldest queued request.
  task automatic waitAck(input string tag, input int latency, input bit keep);
    txn_t t;
    logic [REG_W-1:0] exp_rd;
    logic exp_err;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack === '0 && n < 20);
    if (ack === '0) begin
      checkOutput({tag, "_timeout"}, ack, 1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      checkOutput({tag, "_unexpected_ack"}, ack, 0);
      return;
    end
    t = sb.pop_front();
    exp_err = (int'(t.a) >= NUM_REGS);
    exp_rd  = (exp_err || t.w) ? '0 : model[t.a];
    if (!exp_err && t.w) model[t.a] = t.d;
    checkOutput({tag, "_ack"},   ack,   NUM_REQ'(1) << t.idx);
    checkOutput({tag, "_rdata"}, rdata, exp_rd);
    checkOutput({tag, "_err"},   err,   exp_err);
    checkOutput({tag, "_busy"},  busy,  1);
    checkOutput({tag, "_regs"},  config_regs, model_flat());
    if (latency >= 0) checkOutput({tag, "_latency"}, cyc - t.t0, latency);
    prev_ack = last_ack;
    last_ack = cyc;
    if (!keep) req[t.idx] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    repeat (3) @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    checkOutput("rst_regs",  config_regs, 0);
    checkOutput("rst_ack",   ack, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_err",   err, 0);
    checkOutput("rst_busy",  busy, 0);

    // Single write, then a read of the same address by the other requester
    @(posedge clk); #1 ena = 1'b1;
    applyStimulus(0, 1'b1, 3'd3, 8'hA5);
    waitAck("wr0", 2, 1'b0);
    checkOutput("wr0_reg3", config_regs[31:24], 8'hA5);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 3'd3, 8'h00);
    waitAck("rd1", 2, 1'b0);
    checkOutput("rd1_value", rdata, 8'hA5);

    // Contention: both requesters held high, grants must alternate 0,1,0,1
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 3'd0, 8'h11);
    applyStimulus(1, 1'b1, 3'd0, 8'h22);
    sb.push_back(sb[0]);
    sb.push_back(sb[1]);
    waitAck("rr0", 2, 1'b1);
    waitAck("rr1", -1, 1'b1);
    checkOutput("rr1_spacing", last_ack - prev_ack, 3);
    waitAck("rr2", -1, 1'b0);
    checkOutput("rr2_spacing", last_ack - prev_ack, 3);
    waitAck("rr3", -1, 1'b0);
    checkOutput("rr3_spacing", last_ack - prev_ack, 3);
    checkOutput("rr_final", config_regs[7:0], 8'h22);

    // Out-of-range read and write
    @(posedge clk); #1;
    applyStimulus(0, 1'b0, 3'd7, 8'h00);
    waitAck("oor_rd", 2, 1'b0);
    checkOutput("oor_rd_flag", err, 1);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 3'd6, 8'hFF);
    waitAck("oor_wr", 2, 1'b0);
    checkOutput("oor_wr_flag", err, 1);

    // Enable gating, then drop enable during GRANT
    @(posedge clk); #1 ena = 1'b0;
    applyStimulus(0, 1'b1, 3'd1, 8'h3C);
    repeat (10) begin
      @(negedge clk);
      checkOutput("gate_ack",  ack, 0);
      checkOutput("gate_busy", busy, 0);
    end
    @(posedge clk); #1 ena = 1'b1;
    t_ena = cyc;
    @(posedge clk); #1 ena = 1'b0;
    checkOutput("gate_busy_grant", busy, 1);
    waitAck("gate_wr", -1, 1'b0);
    checkOutput("gate_latency", last_ack - t_ena, 2);

    // Reset during the GRANT cycle of a write
    @(posedge clk); #1 ena = 1'b1;
    applyStimulus(0, 1'b1, 3'd2, 8'h5A);
    sb.delete();
    @(posedge clk); #1;
    checkOutput("rst_mid_busy_grant", busy, 1);
    rstb = 1'b0;
    req  = '0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = '0;
    @(negedge clk);
    checkOutput("rst_mid_regs",  config_regs, 0);
    checkOutput("rst_mid_ack",   ack, 0);
    checkOutput("rst_mid_rdata", rdata, 0);
    checkOutput("rst_mid_busy",  busy, 0);
    @(posedge clk); #1 rstb = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_rst_ack",  ack, 0);
      checkOutput("post_rst_busy", busy, 0);
    end
    checkOutput("post_rst_reg2", config_regs[23:16], 8'h00);
    @(posedge clk); #1;
    applyStimulus(1, 1'b0, 3'd2, 8'h00);
    waitAck("post_rst_rd", 2, 1'b0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
